// File: rtl/ifu_fetch_queue_if.sv
// Fetch-queue bus: icache response in, PC correction and stall back to the
// PC register, buffered instructions out toward decode.
interface ifu_fetch_queue_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
);
  // Fetch side (icache response / PC register)
  logic            flush_i;
  logic [XLEN-1:0] fetch_pc_i;
  logic [31:0]     fetch_data_i;
  logic            fetch_valid_i;
  logic            fetch_ready_o;
  logic            stall_o;
  logic [XLEN-1:0] ifu_next_pc_o;
  logic            ifu_next_pc_valid_o;

  // Decode side
  logic            dec_valid_o;
  logic            dec_ready_i;
  logic [XLEN-1:0] dec_pc_o;
  logic [31:0]     dec_inst_o;
  logic            dec_rvc_o;
  logic            dec_fault_o;
  logic [CW-1:0]   count_o;

  // Upstream/downstream environment that drives the *_i signals
  modport master (
    output flush_i, fetch_pc_i, fetch_data_i, fetch_valid_i, dec_ready_i,
    input  fetch_ready_o, stall_o, ifu_next_pc_o, ifu_next_pc_valid_o,
           dec_valid_o, dec_pc_o, dec_inst_o, dec_rvc_o, dec_fault_o, count_o
  );

  // The fetch queue itself
  modport slave (
    input  flush_i, fetch_pc_i, fetch_data_i, fetch_valid_i, dec_ready_i,
    output fetch_ready_o, stall_o, ifu_next_pc_o, ifu_next_pc_valid_o,
           dec_valid_o, dec_pc_o, dec_inst_o, dec_rvc_o, dec_fault_o, count_o
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: decodes RVC vs 32-bit length of each icache
// response, returns the length-corrected next PC, and buffers entries in a
// small FIFO toward decode. Misaligned PCs and the all-zero RVC encoding are
// tagged as faults and still enqueued so decode can raise the exception.
module ifu_fetch_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input logic              clk,
  input logic              rst,
  ifu_fetch_queue_if.slave bus
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Compressed encodings are every opcode whose low two bits are not 2'b11.
  function automatic logic is_rvc(input logic [1:0] low_bits);
    return (low_bits != 2'b11);
  endfunction

  // Misaligned fetch, or the reserved all-zero compressed instruction.
  function automatic logic entry_fault(input logic pc_bit0, input logic rvc,
                                       input logic [15:0] low_half);
    return pc_bit0 | (rvc & (low_half == 16'h0000));
  endfunction

  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [XLEN-1:0] r_pc    [DEPTH];
  logic [31:0]     r_inst  [DEPTH];
  logic            r_rvc   [DEPTH];
  logic            r_fault [DEPTH];

  logic            w_rvc;
  logic [31:0]     w_inst;
  logic            w_fault;
  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_dec_valid;
  logic [XLEN-1:0] w_next_pc;

  // Length decode, entry formatting and the push/pop handshake qualifiers.
  always_comb begin
    w_rvc       = is_rvc(bus.fetch_data_i[1:0]);
    w_fault     = entry_fault(bus.fetch_pc_i[0], w_rvc, bus.fetch_data_i[15:0]);
    w_ready     = (r_count < FULL_CNT);
    w_push      = bus.fetch_valid_i & w_ready & ~bus.flush_i & ~rst;
    w_dec_valid = (r_count != {CW{1'b0}}) & ~bus.flush_i & ~rst;
    w_pop       = w_dec_valid & bus.dec_ready_i;
    if (w_rvc) begin
      w_inst = {16'h0000, bus.fetch_data_i[15:0]};
    end else begin
      w_inst = bus.fetch_data_i;
    end
    if (rst) begin
      w_next_pc = {XLEN{1'b0}};
    end else if (w_rvc) begin
      w_next_pc = bus.fetch_pc_i + XLEN'(2);
    end else begin
      w_next_pc = bus.fetch_pc_i + XLEN'(4);
    end
  end

  assign bus.fetch_ready_o       = w_ready;
  assign bus.stall_o             = bus.fetch_valid_i & ~w_ready & ~rst;
  assign bus.ifu_next_pc_o       = w_next_pc;
  // The PC register advances by 2 on its own; only 32-bit pushes correct it.
  assign bus.ifu_next_pc_valid_o = w_push & ~w_rvc;
  assign bus.dec_valid_o         = w_dec_valid;
  assign bus.dec_pc_o            = r_pc[r_rd_ptr];
  assign bus.dec_inst_o          = r_inst[r_rd_ptr];
  assign bus.dec_rvc_o           = r_rvc[r_rd_ptr];
  assign bus.dec_fault_o         = r_fault[r_rd_ptr];
  assign bus.count_o             = r_count;

  // Occupancy and pointer bookkeeping; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= {CW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
    end else if (bus.flush_i) begin
      r_count  <= {CW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_wr_ptr <= {AW{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the decode outputs start at zero,
  // left untouched by flush since the pointers already discard the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= {XLEN{1'b0}};
        r_inst[i]  <= 32'h0000_0000;
        r_rvc[i]   <= 1'b0;
        r_fault[i] <= 1'b0;
      end
    end else if (w_push) begin
      r_pc[r_wr_ptr]    <= bus.fetch_pc_i;
      r_inst[r_wr_ptr]  <= w_inst;
      r_rvc[r_wr_ptr]   <= w_rvc;
      r_fault[r_wr_ptr] <= w_fault;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Self-checking bench for ifu_fetch_queue: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_ifu_fetch_queue;

  localparam int XLEN  = 64;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        rvc;
    logic        fault;
  } ent_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  ent_t q[$];

  ifu_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  ifu_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check the cycle's outputs, advance the model.
  task automatic cycle(input logic fv, input logic [63:0] pc, input logic [31:0] data,
                       input logic dr, input logic fl);
    ent_t        e;
    logic        rvc, rdy, push, dv;
    logic [63:0] npc;
    bus.fetch_valid_i = fv;
    bus.fetch_pc_i    = pc;
    bus.fetch_data_i  = data;
    bus.dec_ready_i   = dr;
    bus.flush_i       = fl;
    #3;
    rvc  = (data[1:0] != 2'b11);
    rdy  = (q.size() < DEPTH);
    push = fv && rdy && !fl;
    dv   = (q.size() != 0) && !fl;
    npc  = pc + (rvc ? 64'd2 : 64'd4);
    chk("fetch_ready", bus.fetch_ready_o, rdy);
    chk("stall", bus.stall_o, fv && !rdy);
    chk("next_pc", bus.ifu_next_pc_o, npc);
    chk("next_pc_valid", bus.ifu_next_pc_valid_o, push && !rvc);
    chk("dec_valid", bus.dec_valid_o, dv);
    chk("count", bus.count_o, 64'(q.size()));
    if (dv) begin
      chk("head_pc", bus.dec_pc_o, q[0].pc);
      chk("head_inst", bus.dec_inst_o, q[0].inst);
      chk("head_rvc", bus.dec_rvc_o, q[0].rvc);
      chk("head_fault", bus.dec_fault_o, q[0].fault);
    end
    if (fl) begin
      q.delete();
    end else begin
      if (dv && dr) void'(q.pop_front());
      if (push) begin
        e.pc    = pc;
        e.inst  = rvc ? {16'h0000, data[15:0]} : data;
        e.rvc   = rvc;
        e.fault = pc[0] || (rvc && data[15:0] == 16'h0000);
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.fetch_valid_i = 1'b0;
    bus.fetch_pc_i    = 64'h0000_0000_0000_1234;
    bus.fetch_data_i  = 32'h0000_0413;
    bus.dec_ready_i   = 1'b0;
    bus.flush_i       = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    chk("rst_count", bus.count_o, 64'd0);
    chk("rst_dec_valid", bus.dec_valid_o, 1'b0);
    chk("rst_dec_pc", bus.dec_pc_o, 64'd0);
    chk("rst_dec_inst", bus.dec_inst_o, 64'd0);
    chk("rst_dec_rvc", bus.dec_rvc_o, 1'b0);
    chk("rst_dec_fault", bus.dec_fault_o, 1'b0);
    chk("rst_ready", bus.fetch_ready_o, 1'b1);
    chk("rst_stall", bus.stall_o, 1'b0);
    chk("rst_next_pc", bus.ifu_next_pc_o, 64'd0);
    chk("rst_next_pc_valid", bus.ifu_next_pc_valid_o, 1'b0);
    // A fetch presented while reset is held must not be accepted.
    bus.fetch_valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_no_push", bus.count_o, 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [63:0] rpc;
    logic [31:0] rdata;
    logic        fv, dr, fl, held;

    do_reset();

    // 32-bit instruction, then its head presentation a cycle later
    cycle(1'b1, 64'h8000_0000, 32'h0000_0413, 1'b0, 1'b0);
    chk("tp1_head_pc", bus.dec_pc_o, 64'h8000_0000);
    chk("tp1_head_inst", bus.dec_inst_o, 64'h0000_0413);
    // Compressed c.li
    cycle(1'b1, 64'h8000_0004, 32'hFFFF_4501, 1'b0, 1'b0);
    chk("tp2_count", bus.count_o, 64'd2);
    repeat (3) cycle(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // Fill to full with decode blocked, then stall and single pop
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, 64'h100 + 64'(4 * i), 32'h0000_0013, 1'b0, 1'b0);
    chk("full_count", bus.count_o, 64'd4);
    chk("full_ready", bus.fetch_ready_o, 1'b0);
    cycle(1'b1, 64'h200, 32'h0000_0013, 1'b0, 1'b0);
    cycle(1'b1, 64'h200, 32'h0000_0013, 1'b1, 1'b0);
    chk("pop_from_full_count", bus.count_o, 64'd3);
    cycle(1'b1, 64'h200, 32'h0000_0013, 1'b0, 1'b0);
    chk("refill_count", bus.count_o, 64'd4);

    // Drain to 2, then push+pop together across pointer wrap
    repeat (2) cycle(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      cycle(1'b1, 64'h1000 + 64'(4 * i), 32'h0000_0013, 1'b1, 1'b0);
    chk("pushpop_count", bus.count_o, 64'd2);

    // Flush at count 3 with a coincident fetch
    cycle(1'b1, 64'h2000, 32'h0000_0013, 1'b0, 1'b0);
    cycle(1'b1, 64'h3000, 32'h0000_0013, 1'b1, 1'b1);
    chk("flush_count", bus.count_o, 64'd0);
    cycle(1'b0, 64'd0, 32'd0, 1'b0, 1'b0);

    // Fault cases and next-PC wrap from the top of the address space
    cycle(1'b1, 64'h8000_0001, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cycle(1'b1, 64'h8000_0010, 32'h1234_0000, 1'b0, 1'b0);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, 64'd0, 32'd0, 1'b1, 1'b0);

    // Reset in the middle of traffic at count 2
    cycle(1'b1, 64'h4000, 32'h0000_0013, 1'b0, 1'b0);
    cycle(1'b1, 64'h4004, 32'h0000_4501, 1'b0, 1'b0);
    chk("pre_reset_count", bus.count_o, 64'd2);
    do_reset();

    // Randomized traffic; a stalled response is held until accepted or flushed
    held  = 1'b0;
    rpc   = 64'd0;
    rdata = 32'd0;
    for (int n = 0; n < 500; n++) begin
      if (!held) begin
        rpc   = {$urandom, $urandom};
        if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
        rdata = $urandom;
        case ($urandom_range(0, 3))
          0:       rdata[1:0]  = 2'b11;
          1:       rdata[15:0] = 16'h0000;
          default: ;
        endcase
      end
      fv   = held || ($urandom_range(0, 9) < 7);
      dr   = ($urandom_range(0, 9) < 5);
      fl   = ($urandom_range(0, 19) == 0);
      held = fv && (q.size() >= DEPTH) && !fl;
      cycle(fv, rpc, rdata, dr, fl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register and icache.
- Takes each icache fetch response (PC plus 32 bits starting at that PC) and determines instruction length: RVC (16-bit) or 32-bit.
- Drives the PC-correction pair (next PC / next-PC valid) back to the PC register, and buffers fetched instructions in a small FIFO toward decode.
- Back-pressures the PC register via stall when the buffer cannot accept.

Parameters:
- XLEN, 64, PC width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush_i  in  1  pipeline flush (trap/branch redirect)
- fetch_pc_i  in  XLEN  PC of the current icache response
- fetch_data_i  in  32  raw bytes at fetch_pc_i, little-endian
- fetch_valid_i  in  1  icache response valid
- fetch_ready_o  out  1  queue can accept a response this cycle
- stall_o  out  1  to PC register: hold PC
- ifu_next_pc_o  out  XLEN  length-corrected next PC
- ifu_next_pc_valid_o  out  1  correction valid
- dec_valid_o  out  1  head entry valid toward decode
- dec_ready_i  in  1  decode accepts head
- dec_pc_o  out  XLEN  head PC
- dec_inst_o  out  32  head instruction; RVC has upper 16 bits zeroed
- dec_rvc_o  out  1  head is a compressed instruction
- dec_fault_o  out  1  head is misaligned (pc[0]=1) or an illegal all-zero RVC
- count_o  out  CW  current occupancy

Behaviour:
- Reset: count=0, rd/wr pointers=0, all dec_* outputs 0, fetch_ready_o=1, stall_o=0, ifu_next_pc_valid_o=0, ifu_next_pc_o=0. Reset has priority over flush and all handshakes.
- Accept condition: push = fetch_valid_i & fetch_ready_o & ~flush_i.
- fetch_ready_o = (count < DEPTH). It depends only on registered count; there is no same-cycle pop-through when full.
- stall_o = fetch_valid_i & ~fetch_ready_o (combinational). While stall_o=1, the upstream holds fetch_pc_i/fetch_data_i stable until accepted.
- Length decode (combinational on inputs): rvc = (fetch_data_i[1:0] != 2'b11).
- ifu_next_pc_o = fetch_pc_i + (rvc ? 2 : 4), computed modulo 2^XLEN; wrap from all-ones is legal.
- ifu_next_pc_valid_o = push & ~rvc. The PC register's default is +2, so only 32-bit instructions need correction. It is 0 during flush and 0 when stalled.
- Entry stored on push: {fetch_pc_i, rvc ? {16'b0, data[15:0]} : data, rvc, fault}.
  - fault = fetch_pc_i[0] | (rvc & data[15:0]==16'h0000).
  - A faulted entry is still enqueued; decode raises the exception.
- Pop: pop = dec_valid_o & dec_ready_i & ~flush_i.
- dec_valid_o = (count != 0) & ~flush_i. dec_* present the head entry combinationally from storage and stay stable while dec_valid_o & ~dec_ready_i.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no input-to-output bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. Push without pop: count+1. Pop without push: count-1.
- Pointers wrap modulo DEPTH.
- Full (count==DEPTH): push blocked, stall_o follows fetch_valid_i, pop still allowed. The cycle after a pop, fetch_ready_o=1.
- Empty (count==0): dec_valid_o=0 and dec_* hold last values (don't-care for verification).
- flush_i cycle: no push, no pop, ifu_next_pc_valid_o=0, dec_valid_o=0. Next cycle: count=0 and pointers=0. Entry contents are not cleared.
- Flush coincident with fetch_valid_i: the response is dropped. The upstream re-fetches from the redirect PC.

Test Plan:
- Reset then fetch_pc_i=0x80000000, data=0x00000413 (32-bit) -> ifu_next_pc_valid_o=1, ifu_next_pc_o=0x80000004; next cycle dec_valid_o=1, dec_pc_o=0x80000000, dec_inst_o=0x00000413, dec_rvc_o=0.
- Fetch pc=0x80000004, data=0xFFFF4501 (RVC c.li) -> ifu_next_pc_valid_o=0, ifu_next_pc_o=0x80000006; enqueued dec_inst_o=0x00004501, dec_rvc_o=1, dec_fault_o=0.
- dec_ready_i=0 with DEPTH=4 consecutive fetches -> count_o=4, fetch_ready_o=0; 5th fetch_valid_i gives stall_o=1, ifu_next_pc_valid_o=0, no push. Raise dec_ready_i for 1 cycle -> count_o=3, next cycle the 5th entry is accepted and count_o returns to 4.
- Simultaneous push and pop at count=2 -> count_o stays 2. The head advances in FIFO order across pointer wrap (verify over 10 entries with sequential PCs).
- count=3 and flush_i=1 together with fetch_valid_i=1 -> that cycle dec_valid_o=0, stall_o=0, no push; next cycle count_o=0, dec_valid_o=0.
- Fault cases: pc=0x80000001, any data -> dec_fault_o=1. pc=0x80000010, data=0x12340000 -> dec_rvc_o=1, dec_fault_o=1, dec_inst_o=0. rst asserted mid-stream at count=2 -> count_o=0 next cycle.
